// File: rtl/shift_normalizer.sv
// shift_normalizer: iterative normalizer that shifts a word one bit per cycle
// until its MSB (left mode) or LSB (right mode) is set. It reports the
// normalized word, the number of shifts applied and an all-zero indication.
module shift_normalizer #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     shift_direction,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(WIDTH)-1:0] shift_amount,
  output logic                     zero_flag,
  output logic                     busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work, work_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             zf, zf_nxt;
  logic             dir, dir_nxt;
  logic             out_valid_nxt;
  logic             busy_nxt;

  // in_ready depends on the state register only, never on inputs
  assign in_ready     = (state == IDLE);
  assign data_out     = work;
  assign shift_amount = cnt;
  assign zero_flag    = zf;

  // Next-state and datapath decisions; flush always wins over other events
  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    cnt_nxt   = cnt;
    zf_nxt    = zf;
    dir_nxt   = dir;
    unique case (state)
      IDLE: begin
        if (!flush && in_valid) begin
          work_nxt  = data_in;
          dir_nxt   = shift_direction;
          cnt_nxt   = '0;
          zf_nxt    = 1'b0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (flush) begin
          zf_nxt    = 1'b0;
          state_nxt = IDLE;
        end else if (work == '0) begin
          zf_nxt    = 1'b1;
          cnt_nxt   = '0;
          work_nxt  = '0;
          state_nxt = DONE;
        end else if (dir ? work[WIDTH-1] : work[0]) begin
          state_nxt = DONE;
        end else begin
          // A nonzero word reaches its target bit within WIDTH-1 shifts,
          // so the counter cannot wrap.
          work_nxt = dir ? {work[WIDTH-2:0], 1'b0} : {1'b0, work[WIDTH-1:1]};
          cnt_nxt  = cnt + CW'(1);
        end
      end
      DONE: begin
        if (flush) begin
          zf_nxt    = 1'b0;
          state_nxt = IDLE;
        end else if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    out_valid_nxt = (state_nxt == DONE);
    busy_nxt      = (state_nxt != IDLE);
  end

  // State, working register and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      zf        <= 1'b0;
      dir       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      work      <= work_nxt;
      cnt       <= cnt_nxt;
      zf        <= zf_nxt;
      dir       <= dir_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_shift_normalizer.sv
// tb_shift_normalizer: directed and randomized checks of shift_normalizer
// against a reference model built from bit positions of the input word.
module tb_shift_normalizer;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          shift_direction = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          in_ready, out_valid, zero_flag, busy;
  logic [W-1:0]  data_out;
  logic [CW-1:0] shift_amount;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  shift_normalizer #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .data_in        (data_in),
    .shift_direction(shift_direction),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .data_out       (data_out),
    .shift_amount   (shift_amount),
    .zero_flag      (zero_flag),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: leading/trailing zero count from the highest/lowest set bit.
  function automatic void ref_norm(input logic [W-1:0] d, input logic left,
                                   output logic [W-1:0] q, output int k, output logic z);
    int hi;
    int lo;
    hi = -1;
    lo = -1;
    z  = (d == '0);
    for (int i = 0; i < W; i++) begin
      if (d[i]) begin
        hi = i;
        if (lo < 0) lo = i;
      end
    end
    if (z) begin
      q = '0;
      k = 0;
    end else if (left) begin
      k = W - 1 - hi;
      q = d << k;
    end else begin
      k = lo;
      q = d >> k;
    end
  endfunction

  // Runs one word; called and returns at a falling edge.
  task automatic do_word(input logic [W-1:0] d, input logic left, input bit rnd_ready, input int hold);
    logic [W-1:0] eq;
    logic [W-1:0] back;
    int           ek;
    logic         ez;
    int           lat;
    int           g;
    ref_norm(d, left, eq, ek, ez);
    g = 0;
    while (!in_ready && g < 64) begin
      @(negedge clk);
      g++;
    end
    chk("accept_rdy", 32'(in_ready), 32'd1);
    data_in = d;
    shift_direction = left;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in = W'($urandom);
    shift_direction = 1'($urandom_range(0, 1));
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < W + 4);
    chk("out_valid_rise", 32'(out_valid), 32'd1);
    if (!out_valid) return;
    chk("latency", 32'(lat), 32'(ek + 1));
    chk("data_out", 32'(data_out), 32'(eq));
    chk("shift_amount", 32'(shift_amount), 32'(ek));
    chk("zero_flag", 32'(zero_flag), 32'(ez));
    if (!ez) begin
      back = left ? (data_out >> shift_amount) : (data_out << shift_amount);
      chk("roundtrip", 32'(back), 32'(d));
    end
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid = (i == 2);
      data_in = 8'hFF;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(data_out), 32'(eq));
      chk("bp_amount", 32'(shift_amount), 32'(ek));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    g = 0;
    while (1) begin
      out_ready = (rnd_ready && g < 16) ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(data_out), 32'(eq));
      chk("hold_amount", 32'(shift_amount), 32'(ek));
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      if (out_ready) break;
      @(negedge clk);
      g++;
    end
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic start_word(input logic [W-1:0] d, input logic left);
    data_in = d;
    shift_direction = left;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] d;
    bit seen;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_shift_amount", 32'(shift_amount), 32'd0);
    chk("rst_zero_flag", 32'(zero_flag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed words
    do_word(8'h10, 1'b1, 1'b0, 0);
    do_word(8'h28, 1'b0, 1'b0, 0);
    do_word(8'h01, 1'b0, 1'b0, 0);
    do_word(8'h00, 1'b1, 1'b0, 0);
    do_word(8'h00, 1'b0, 1'b0, 0);
    do_word(8'h01, 1'b1, 1'b0, 0);
    do_word(8'h80, 1'b0, 1'b0, 0);
    // Backpressure with an ignored in_valid pulse
    do_word(8'h03, 1'b1, 1'b0, 5);

    // Flush two cycles into a left 0x01 operation
    start_word(8'h01, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_zero_flag", 32'(zero_flag), 32'd0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);

    // Flush in IDLE blocks acceptance
    in_valid = 1'b1;
    flush = 1'b1;
    data_in = 8'h55;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_idle_busy", 32'(busy), 32'd0);
    chk("flush_idle_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Asynchronous reset mid-shift
    start_word(8'h01, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_data_out", 32'(data_out), 32'd0);
    chk("arst_shift_amount", 32'(shift_amount), 32'd0);
    chk("arst_zero_flag", 32'(zero_flag), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_word(8'h40, 1'b1, 1'b0, 0);

    // Randomized words, both directions, random consumer readiness
    repeat (1000) begin
      d = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      do_word(d, 1'($urandom_range(0, 1)), 1'b1, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
